prefix_accum: RTL

PREFIX_ACCUM -- requirements
Module: prefix_accum

---
 rtl/prefix_accum_if.sv | 29 ++
 rtl/prefix_accum.sv | 115 +++++++++++
 2 files changed

// File: rtl/prefix_accum_if.sv
// Handshake and memory-port bundle for prefix_accum.
// slave = the accumulator itself, master = the requester / memory side.
interface prefix_accum_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W:0]   n;
    logic              mode;
    logic              a_rd_en;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_rdata;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] return_val;

    modport slave (
        input  start, n, mode, a_rdata,
        output a_rd_en, a_addr, b_we, b_addr, b_wdata, busy, done, return_val
    );

    modport master (
        output start, n, mode, a_rdata,
        input  a_rd_en, a_addr, b_we, b_addr, b_wdata, busy, done, return_val
    );
endinterface

// File: rtl/prefix_accum.sv
// Prefix-sum / reduction engine: reads A[0..count-1], optionally writes running sums to B.
// Define PREFIX_ACCUM_SAT_EN for unsigned saturating accumulation instead of wrap-around.
module prefix_accum #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    prefix_accum_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        RD   = 4'b0010,
        ACC  = 4'b0100,
        FIN  = 4'b1000
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] ret_q, ret_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] accSum;
    logic [ADDR_W:0]   nClamp;
    logic              lastElem;

`ifdef PREFIX_ACCUM_SAT_EN
    logic [DATA_W:0] wideSum;

    // The carry out of the widened add marks overflow; pin to all-ones.
    always_comb begin
        wideSum = {1'b0, sum_q} + {1'b0, bus.a_rdata};
        accSum  = wideSum[DATA_W] ? {DATA_W{1'b1}} : wideSum[DATA_W-1:0];
    end
`else
    always_comb begin
        accSum = sum_q + bus.a_rdata;
    end
`endif

    assign nClamp   = (bus.n > DEPTH_C) ? DEPTH_C : bus.n;
    assign lastElem = (({1'b0, i_q}) + (ADDR_W+1)'(1)) == count_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            i_q     <= '0;
            sum_q   <= '0;
            ret_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            i_q     <= i_d;
            sum_q   <= sum_d;
            ret_q   <= ret_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        i_d         = i_q;
        sum_d       = sum_q;
        ret_d       = ret_q;
        mode_d      = mode_q;
        bus.a_rd_en = 1'b0;
        bus.a_addr  = i_q;
        bus.b_we    = 1'b0;
        bus.b_addr  = i_q;
        bus.b_wdata = accSum;
        bus.done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    count_d = nClamp;
                    mode_d  = bus.mode;
                    sum_d   = '0;
                    i_d     = '0;
                    state_d = (nClamp != '0) ? RD : FIN;
                end
            end
            RD: begin
                bus.a_rd_en = 1'b1;
                state_d     = ACC;
            end
            ACC: begin
                sum_d    = accSum;
                bus.b_we = !mode_q;
                // Holding i on the last element keeps it inside the address range.
                if (lastElem) begin
                    state_d = FIN;
                end else begin
                    i_d     = i_q + ADDR_W'(1);
                    state_d = RD;
                end
            end
            FIN: begin
                bus.done = 1'b1;
                ret_d    = sum_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.return_val = ret_q;
endmodule
